bus_latency_responder: RTL and testbench

- Synthesizable, parametrised bus slave with internal word memory.
- Inserts programmable or pseudo-random wait-request stalls and read-return latency.
- Supports multiple outstanding in-order reads.
- Replaces the fixed zero-wait test RAM in CPU-level benches, so data-path memory accesses see the same stall and latency stress as injected fetches.

---
 rtl/bus_latency_responder_if.sv | 28 ++
 rtl/bus_latency_responder.sv | 183 ++++++++++++++++++
 tb/tb_bus_latency_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_latency_responder_if.sv
// Bus between a CPU-side master and the latency-injecting memory slave.
// Latency: none (wires only).
// Backpressure: waitRequest from the slave holds the master's command in place.
// Ports: read/write/address/byteWriteEnable/dataIn from the master;
//        waitRequest/readValid/dataOut from the slave.
interface bus_latency_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    read;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteWriteEnable;
  logic [DATA_WIDTH-1:0]   dataIn;
  logic                    waitRequest;
  logic                    readValid;
  logic [DATA_WIDTH-1:0]   dataOut;

  modport master (
    output read, write, address, byteWriteEnable, dataIn,
    input  waitRequest, readValid, dataOut
  );

  modport slave (
    input  read, write, address, byteWriteEnable, dataIn,
    output waitRequest, readValid, dataOut
  );
endinterface

// File: rtl/bus_latency_responder.sv
// Word-memory bus slave that injects wait-request stalls and in-order read latency.
// Latency: W stall cycles before acceptance, read data L>=1 cycles after acceptance.
// Backpressure: waitRequest while stalling or while a read would overflow the response queue.
// Ports: clk, reset (async active-low), bus (slave modport), mode/fixedWait/fixedLatency
//        delay controls, protocolError sticky flag.
// Optional: define BUS_LATENCY_RANDOM_EN to build the LFSR and enable mode 2 (random);
//           without it mode 2 behaves as mode 1.
module bus_latency_responder #(
  parameter int              DATA_WIDTH      = 32,
  parameter int              ADDR_WIDTH      = 10,
  parameter int              MAX_OUTSTANDING = 4,
  parameter int              LAT_WIDTH       = 3,
  parameter logic [15:0]     LFSR_SEED       = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_latency_responder_if.slave bus,
  input  logic [1:0]           mode,
  input  logic [LAT_WIDTH-1:0] fixedWait,
  input  logic [LAT_WIDTH-1:0] fixedLatency,
  output logic                 protocolError
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int LANES = DATA_WIDTH / 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [0:0]           state;
  logic [LAT_WIDTH-1:0] cnt;
  logic [1:0]           effMode;
  logic [LAT_WIDTH-1:0] waitSel;
  logic [LAT_WIDTH-1:0] latSel;
  logic                 req, isRead, full, headPop, blocked, waitReq, accept, pushRd, doWrite;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] memRd;

  logic [DATA_WIDTH-1:0] qData [MAX_OUTSTANDING];
  logic [LAT_WIDTH-1:0]  qCnt  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      rdPtr, wrPtr;
  logic [CNT_W-1:0]      qCount;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef BUS_LATENCY_RANDOM_EN
  logic [15:0] lfsr;

  // Fibonacci taps 16,14,13,11; stepping only on acceptance keeps the delay
  // sequence independent of how long the master idles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`else
  logic unusedSeed;
  assign unusedSeed = ^LFSR_SEED;
`endif

  // Mode 3 is reserved and folds to 0; without the LFSR, random folds to fixed.
  always_comb begin
    effMode = mode;
    if (mode == 2'd3) effMode = 2'd0;
`ifndef BUS_LATENCY_RANDOM_EN
    if (mode == 2'd2) effMode = 2'd1;
`endif
  end

  always_comb begin
    waitSel = '0;
    latSel  = LAT_WIDTH'(1);
    case (effMode)
      2'd1: begin
        waitSel = fixedWait;
        latSel  = (fixedLatency == '0) ? LAT_WIDTH'(1) : fixedLatency;
      end
`ifdef BUS_LATENCY_RANDOM_EN
      2'd2: begin
        waitSel = lfsr[LAT_WIDTH-1:0];
        latSel  = (lfsr[2*LAT_WIDTH-1:LAT_WIDTH] == '0) ? LAT_WIDTH'(1)
                                                        : lfsr[2*LAT_WIDTH-1:LAT_WIDTH];
      end
`endif
      default: ;
    endcase
  end

  assign req     = bus.read | bus.write;
  assign isRead  = bus.read & ~bus.write;
  assign full    = (qCount == CNT_W'(MAX_OUTSTANDING));
  assign headPop = (qCount != '0) && (qCnt[rdPtr] == '0);
  // A full queue only blocks when the head is not leaving on this same edge.
  assign blocked = isRead & full & ~headPop;

  always_comb begin
    waitReq = 1'b0;
    if (req) begin
      if (state == IDLE) waitReq = (waitSel != '0) | blocked;
      else               waitReq = (cnt != '0) | blocked;
    end
  end

  assign bus.waitRequest = waitReq;
  assign accept  = req & ~waitReq;
  assign pushRd  = accept & isRead;
  assign doWrite = accept & bus.write;

  // cnt is loaded with W-1 because the IDLE cycle that detects the request
  // is itself the first stall cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      protocolError <= 1'b0;
    end else begin
      if (bus.read & bus.write) protocolError <= 1'b1;
      case (state)
        IDLE: begin
          if (req && waitSel != '0) begin
            state <= STALL;
            cnt   <= waitSel - LAT_WIDTH'(1);
          end
        end
        STALL: begin
          if (!req) begin
            state         <= IDLE;
            protocolError <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - LAT_WIDTH'(1);
          end else if (!blocked) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int b = 0; b < LANES; b++) begin
        if (bus.byteWriteEnable[b]) mem[bus.address][8*b +: 8] <= bus.dataIn[8*b +: 8];
      end
    end
  end

  assign memRd = mem[bus.address];

  always_ff @(posedge clk) begin
    if (pushRd) qData[wrPtr] <= memRd;
  end

  // Every slot counts down and saturates; an entry that reached zero behind
  // the head simply leaves on the cycle after its predecessor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr         <= '0;
      wrPtr         <= '0;
      qCount        <= '0;
      bus.readValid <= 1'b0;
      bus.dataOut   <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) qCnt[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (qCnt[i] != '0) qCnt[i] <= qCnt[i] - LAT_WIDTH'(1);
      end
      bus.readValid <= headPop;
      if (headPop) begin
        bus.dataOut <= qData[rdPtr];
        rdPtr       <= nextPtr(rdPtr);
      end
      if (pushRd) begin
        qCnt[wrPtr] <= latSel - LAT_WIDTH'(1);
        wrPtr       <= nextPtr(wrPtr);
      end
      qCount <= qCount + CNT_W'(pushRd) - CNT_W'(headPop);
    end
  end
endmodule

// File: tb/tb_bus_latency_responder.sv
// Randomized and directed bench for bus_latency_responder against a
// transaction-level model (acceptance edge, response edge, memory image).
module tb_bus_latency_responder;
  localparam int          DW   = 32;
  localparam int          AW   = 10;
  localparam int          MO   = 4;
  localparam int          LW   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] mode;
  logic [LW-1:0] fixedWait, fixedLatency;
  logic protocolError;

  always #5 clk = ~clk;

  bus_latency_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bus_latency_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO), .LAT_WIDTH(LW), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .mode(mode),
    .fixedWait(fixedWait), .fixedLatency(fixedLatency), .protocolError(protocolError)
  );

  typedef struct { int acc; int resp; logic [DW-1:0] data; } resp_t;

  resp_t         expQ[$];
  logic [DW-1:0] mm [0:(1<<AW)-1];
  logic [15:0]   mLfsr = SEED;
  int            lastResp = 0;
  logic [DW-1:0] lastData = '0;
  int            tests = 0, fails = 0;
  int            cyc = 0;
  int            lastRespCyc = -1;
  logic [DW-1:0] lastRespVal = '0;
  int            rvCount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Response monitor: the model says exactly which cycle each read returns.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_readValid", bus.readValid, 1'b0);
      check("rst_dataOut", bus.dataOut, '0);
      check("rst_protocolError", protocolError, 1'b0);
    end else begin
      bit due;
      due = (expQ.size() > 0) && (expQ[0].resp == cyc);
      check("readValid", bus.readValid, due);
      if (due) begin
        check("dataOut", bus.dataOut, expQ[0].data);
        lastData = expQ[0].data;
        void'(expQ.pop_front());
      end else begin
        check("dataOut_hold", bus.dataOut, lastData);
      end
      if (bus.readValid) begin
        lastRespCyc = cyc;
        lastRespVal = bus.dataOut;
        rvCount++;
      end
    end
  end

  function automatic logic [15:0] lfsrStep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int effMode();
    int m = int'(mode);
    if (m == 3) m = 0;
`ifndef BUS_LATENCY_RANDOM_EN
    if (m == 2) m = 1;
`endif
    return m;
  endfunction

  // Reads that occupy the queue across edge e (the one leaving at e does not count).
  function automatic int busyAt(input int e);
    int n = 0;
    foreach (expQ[i]) if (expQ[i].acc < e && expQ[i].resp > e) n++;
    return n;
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic cmd(input logic rd, input logic wr, input logic [AW-1:0] addr,
                     input logic [DW/8-1:0] bwe, input logic [DW-1:0] d, output int stalls);
    int t0, w, lat, acc, m;
    resp_t ent;
    bus.read = rd; bus.write = wr; bus.address = addr; bus.byteWriteEnable = bwe; bus.dataIn = d;
    m   = effMode();
    w   = (m == 0) ? 0 : (m == 1) ? int'(fixedWait)    : int'(mLfsr[LW-1:0]);
    lat = (m == 0) ? 1 : (m == 1) ? int'(fixedLatency) : int'(mLfsr[2*LW-1:LW]);
    if (lat < 1) lat = 1;
    t0  = cyc + 1;
    acc = t0 + w;
    if (rd && !wr) while (busyAt(acc) >= MO) acc++;
    if (wr) begin
      for (int b = 0; b < DW/8; b++) if (bwe[b]) mm[addr][8*b +: 8] = d[8*b +: 8];
    end else begin
      ent.acc  = acc;
      ent.resp = (acc + lat > lastResp + 1) ? acc + lat : lastResp + 1;
      ent.data = mm[addr];
      lastResp = ent.resp;
      expQ.push_back(ent);
    end
    mLfsr  = lfsrStep(mLfsr);
    stalls = 0;
    for (int e = t0; e <= acc; e++) begin
      #1;
      check("waitRequest", bus.waitRequest, e != acc);
      if (bus.waitRequest) stalls++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.read = 1'b0; bus.write = 1'b0;
    repeat (n) begin
      #1; check("waitRequest_idle", bus.waitRequest, 1'b0);
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic doReset(input int n);
    bus.read = 1'b0; bus.write = 1'b0;
    @(negedge clk); #2 reset = 1'b0;
    expQ.delete(); mLfsr = SEED; lastData = '0; lastResp = 0;
    repeat (n) @(negedge clk);
    #1 check("rst_waitRequest", bus.waitRequest, 1'b0);
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int s, a, rv0;
    int st[6];
    bus.read = 0; bus.write = 0; bus.address = '0; bus.byteWriteEnable = '0; bus.dataIn = '0;
    mode = 2'd0; fixedWait = '0; fixedLatency = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    check("init_readValid", bus.readValid, 1'b0);
    check("init_dataOut", bus.dataOut, 32'h0);
    check("init_protocolError", protocolError, 1'b0);
    check("init_waitRequest", bus.waitRequest, 1'b0);
    #2 reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) cmd(0, 1, AW'(i), 4'hF, $urandom, s);

    // Zero-wait write then read: response one cycle after acceptance.
    lastRespCyc = -1;
    cmd(0, 1, 5, 4'hF, 32'hDEADBEEF, s);
    check("m0_write_stalls", s, 0);
    cmd(1, 0, 5, 4'h0, '0, s);
    a = cyc;
    idle(3);
    check("m0_read_stalls", s, 0);
    check("m0_latency", lastRespCyc - a, 1);
    check("m0_data", lastRespVal, 32'hDEADBEEF);

    // Fixed wait 3 / latency 4.
    mode = 2'd1; fixedWait = 3; fixedLatency = 4;
    cmd(1, 0, 5, 4'h0, '0, s);
    a = cyc;
    idle(6);
    check("m1_stalls", s, 3);
    check("m1_latency", lastRespCyc - a, 4);
    check("m1_data", lastRespVal, 32'hDEADBEEF);

    // Six back-to-back reads against a depth-4 queue.
    fixedWait = 0; fixedLatency = 6;
    rv0 = rvCount;
    for (int i = 0; i < 6; i++) cmd(1, 0, AW'(i), 4'h0, '0, st[i]);
    idle(12);
    check("b2b_stall_r4", st[3], 0);
    check("b2b_stall_r5", st[4], 2);
    check("b2b_stall_r6", st[5], 0);
    check("b2b_responses", rvCount - rv0, 6);

    // Byte-lane merge.
    mode = 2'd0;
    cmd(0, 1, 9, 4'hF, 32'hFFFFFFFF, s);
    cmd(0, 1, 9, 4'b0101, 32'h11223344, s);
    cmd(1, 0, 9, 4'h0, '0, s);
    idle(3);
    check("bwe_merge", lastRespVal, 32'hFF22FF44);

    // Read+write together acts as a write and flags an error.
    check("perr_clear", protocolError, 1'b0);
    cmd(1, 1, 7, 4'hF, 32'hA5A5_5A5A, s);
    idle(1);
    check("perr_rw", protocolError, 1'b1);
    cmd(1, 0, 7, 4'h0, '0, s);
    idle(3);
    check("rw_as_write", lastRespVal, 32'hA5A5_5A5A);
    doReset(2);
    check("perr_after_reset", protocolError, 1'b0);

    // Request withdrawn during a stall.
    mode = 2'd1; fixedWait = 3; fixedLatency = 1;
    bus.read = 1'b1; bus.address = 7;
    #1 check("stall_wait", bus.waitRequest, 1'b1);
    @(posedge clk); @(negedge clk);
    bus.read = 1'b0;
    #1 check("drop_wait", bus.waitRequest, 1'b0);
    @(posedge clk); @(negedge clk);
    check("perr_drop", protocolError, 1'b1);
    idle(5);
    check("perr_sticky", protocolError, 1'b1);
    doReset(2);
    check("perr_drop_reset", protocolError, 1'b0);

    // Reset with three reads in flight.
    fixedWait = 0; fixedLatency = 7;
    for (int i = 0; i < 3; i++) cmd(1, 0, 5, 4'h0, '0, s);
    rv0 = rvCount;
    doReset(3);
    idle(10);
    check("reset_drops_reads", rvCount - rv0, 0);
    mode = 2'd0;
    cmd(1, 0, 5, 4'h0, '0, s);
    idle(3);
    check("mem_retained", lastRespVal, 32'hDEADBEEF);

    // Random traffic across all modes.
    for (int n = 0; n < 400; n++) begin
      int op;
      if (n % 25 == 0) begin
        mode = 2'($urandom_range(0, 3));
        fixedWait = LW'($urandom_range(0, 3));
        fixedLatency = LW'($urandom_range(0, 7));
      end
      op = $urandom_range(0, 4);
      if (op == 0) cmd(0, 1, AW'($urandom_range(0, 15)), 4'($urandom), $urandom, s);
      else if (op < 4) cmd(1, 0, AW'($urandom_range(0, 15)), 4'h0, '0, s);
      else idle($urandom_range(1, 3));
    end
    idle(40);
    check("drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
